// File: rtl/instr_encoder_if.sv
// Field/word handshake bundle for instr_encoder: decoded fields in, packed word out.
`timescale 1ns/1ps
interface instr_encoder_if;
  logic        iValid;
  logic        oReady;
  logic [2:0]  iFormat;
  logic [10:0] iOpcode;
  logic [4:0]  iRd;
  logic [4:0]  iRn;
  logic [4:0]  iRm;
  logic [5:0]  iShamt;
  logic [63:0] iImm;
  logic        oValid;
  logic        iReady;
  logic [31:0] oInstr;
  logic [63:0] oAddr;
  logic        oError;
  logic [1:0]  oErrCode;

  modport slave (
    input  iValid, iFormat, iOpcode, iRd, iRn, iRm, iShamt, iImm, iReady,
    output oReady, oValid, oInstr, oAddr, oError, oErrCode
  );

  modport master (
    output iValid, iFormat, iOpcode, iRd, iRn, iRm, iShamt, iImm, iReady,
    input  oReady, oValid, oInstr, oAddr, oError, oErrCode
  );
endinterface

// File: rtl/instr_encoder.sv
// LEGv8 field encoder: range/alignment-checks an immediate, packs a 32-bit
// instruction word and emits it with a sequential instruction-memory address.
`timescale 1ns/1ps
module instr_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iClear,
  instr_encoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_e;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_D, FMT_B, FMT_CB, FMT_IW} fmt_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_FORMAT} err_e;

  state_e      state;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic        error_q;
  logic [1:0]  code_q;
  logic [63:0] addr_q;
  logic        clr_pend;

  logic [2:0]  fmt_q;
  logic [10:0] opc_q;
  logic [4:0]  rd_q;
  logic [4:0]  rn_q;
  logic [4:0]  rm_q;
  logic [5:0]  shamt_q;
  logic [63:0] imm_q;

  logic [31:0] word_c;
  err_e        code_c;
  logic        fits_i, fits_d, fits_b, fits_cb, fits_iw, aligned;

  // A value fits a signed field when every bit above the field's sign bit matches it.
  always_comb begin
    fits_i  = ~|imm_q[63:12];
    fits_iw = ~|imm_q[63:16];
    fits_d  = (&imm_q[63:8])  | (~|imm_q[63:8]);
    fits_b  = (&imm_q[63:27]) | (~|imm_q[63:27]);
    fits_cb = (&imm_q[63:20]) | (~|imm_q[63:20]);
    aligned = ~|imm_q[1:0];
  end

  always_comb begin
    word_c = '0;
    code_c = ERR_NONE;
    case (fmt_q)
      FMT_R: begin
        word_c = {opc_q, rm_q, shamt_q, rn_q, rd_q};
      end
      FMT_I: begin
        word_c = {opc_q[10:1], imm_q[11:0], rn_q, rd_q};
        if (!fits_i) code_c = ERR_RANGE;
      end
      FMT_D: begin
        word_c = {opc_q, imm_q[8:0], 2'b00, rn_q, rd_q};
        if (!fits_d) code_c = ERR_RANGE;
      end
      FMT_B: begin
        word_c = {opc_q[10:5], imm_q[27:2]};
        if (!aligned)     code_c = ERR_ALIGN;
        else if (!fits_b) code_c = ERR_RANGE;
      end
      FMT_CB: begin
        word_c = {opc_q[10:3], imm_q[20:2], rd_q};
        if (!aligned)      code_c = ERR_ALIGN;
        else if (!fits_cb) code_c = ERR_RANGE;
      end
      FMT_IW: begin
        word_c = {opc_q[10:2], shamt_q[1:0], imm_q[15:0], rd_q};
        if (!fits_iw) code_c = ERR_RANGE;
      end
      default: code_c = ERR_FORMAT;
    endcase
    if (code_c != ERR_NONE) word_c = '0;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      error_q  <= 1'b0;
      code_q   <= '0;
      addr_q   <= BASE_ADDR;
      clr_pend <= 1'b0;
      fmt_q    <= '0;
      opc_q    <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shamt_q  <= '0;
      imm_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iClear) addr_q <= BASE_ADDR;
          if (bus.iValid) begin
            fmt_q   <= bus.iFormat;
            opc_q   <= bus.iOpcode;
            rd_q    <= bus.iRd;
            rn_q    <= bus.iRn;
            rm_q    <= bus.iRm;
            shamt_q <= bus.iShamt;
            imm_q   <= bus.iImm;
            ready_q <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (iClear) addr_q <= BASE_ADDR;
          instr_q <= word_c;
          error_q <= (code_c != ERR_NONE);
          code_q  <= code_c;
          valid_q <= 1'b1;
          state   <= EMIT;
        end
        EMIT: begin
          // oAddr must stay put while the word is offered, so a clear seen
          // here is remembered and applied at handshake instead of the +4.
          if (bus.iReady) begin
            if (iClear || clr_pend) addr_q <= BASE_ADDR;
            else if (!error_q)      addr_q <= addr_q + 64'd4;
            clr_pend <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end else if (iClear) begin
            clr_pend <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReady   = ready_q;
  assign bus.oValid   = valid_q;
  assign bus.oInstr   = instr_q;
  assign bus.oAddr    = addr_q;
  assign bus.oError   = error_q;
  assign bus.oErrCode = code_q;

endmodule
